// File: rtl/seq_detect_param.sv
// Run-time configurable Moore serial-pattern detector (1..MAX_LEN bit pattern, overlap/non-overlap).
// Optional saturating match counter: define SEQ_DETECT_COUNT_EN to build it in.
module seq_detect_param #(
    parameter int                  MAX_LEN   = 8,
    parameter logic [MAX_LEN-1:0]  RESET_PAT = MAX_LEN'(8'b0000_0001),
    parameter int                  RESET_LEN = 4,
    parameter int                  CNT_W     = 8,
    parameter int                  LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               seq_in,
    input  logic               seq_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               seq_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_W   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RESET_LEN_W = LEN_W'(RESET_LEN);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               match_q;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               match_next;

    assign accept    = seq_valid && !cfg_load;
    assign hist_next = {hist_q[MAX_LEN-2:0], seq_in};
    assign fill_next = (fill_q == len_q) ? len_q : fill_q + 1'b1;

    assign cfg_len_clamped = (cfg_len == '0 || cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) len_mask[i] = 1'b1;
        end
    end

    // History bits above len are masked out of the compare.
    assign match_next = (fill_next == len_q) &&
                        (((hist_next ^ pattern_q) & len_mask) == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            pattern_q <= RESET_PAT;
            len_q     <= RESET_LEN_W;
            overlap_q <= 1'b0;
        end else if (cfg_load) begin
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_clamped;
            overlap_q <= cfg_overlap;
        end else if (accept) begin
            hist_q  <= hist_next;
            match_q <= match_next;
            // Non-overlap mode restarts the fill so the next match needs len fresh bits.
            fill_q  <= (match_next && !overlap_q) ? '0 : fill_next;
        end
    end

    assign seq_out = match_q;

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (cfg_load) begin
            count_q <= '0;
        end else if (accept && match_next && count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule
